// File: rtl/slc3_test_top.sv
// SLC-3 (16-bit LC-3 subset) CPU with preloaded on-chip test RAM, switch/button
// inputs, LED pause indicator and six 7-segment digits (hex register + PC[7:0]).
module slc3_test_top #(
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic       Clk,
  input  logic       Run,
  input  logic       Continue,
  input  logic [9:0] SW,
  output logic [9:0] LED,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5
);

  localparam int unsigned AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  localparam logic [3:0] OP_BR    = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_JSR   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_LDR   = 4'h6;
  localparam logic [3:0] OP_STR   = 4'h7;
  localparam logic [3:0] OP_NOT   = 4'h9;
  localparam logic [3:0] OP_JMP   = 4'hC;
  localparam logic [3:0] OP_PAUSE = 4'hD;

  localparam logic [15:0] IO_ADDR = 16'hFFFF;

  typedef logic [MEM_WORDS-1:0][15:0] mem_t;

  typedef enum logic [4:0] {
    S_HALTED   = 5'd0,
    S_FETCH1   = 5'd1,
    S_FETCH2   = 5'd2,
    S_FETCH3   = 5'd3,
    S_DECODE   = 5'd4,
    S_ALU      = 5'd5,
    S_BR       = 5'd6,
    S_JMP      = 5'd7,
    S_JSR      = 5'd8,
    S_LDR1     = 5'd9,
    S_LDR2     = 5'd10,
    S_LDR3     = 5'd11,
    S_STR1     = 5'd12,
    S_STR2     = 5'd13,
    S_STR3     = 5'd14,
    S_PAUSE_HI = 5'd15,
    S_PAUSE_LO = 5'd16
  } state_t;

  // Test program image: boot stub, three I/O loops, XOR test, multiply test.
  function automatic logic [15:0] boot_word(input int unsigned a);
    case (a)
      // boot stub: R0<=0; R1<=SW; JMP R1
      32'h00: return 16'h5020;
      32'h01: return 16'h623F;
      32'h02: return 16'hC040;
      // I/O test at 0x03 falls into the loop at 0x06
      32'h03: return 16'hD003;
      32'h04: return 16'h623F;
      32'h05: return 16'h723F;
      32'h06: return 16'hD006;
      32'h07: return 16'h623F;
      32'h08: return 16'h723F;
      32'h09: return 16'h0FFC;
      32'h0B: return 16'hD00B;
      32'h0C: return 16'h623F;
      32'h0D: return 16'h723F;
      32'h0E: return 16'h0FFC;
      // XOR test: hex <= A ^ B built from AND/NOT
      32'h14: return 16'hD0A1;
      32'h15: return 16'h623F;
      32'h16: return 16'hD0B1;
      32'h17: return 16'h643F;
      32'h18: return 16'h96BF;
      32'h19: return 16'h5643;
      32'h1A: return 16'h987F;
      32'h1B: return 16'h5902;
      32'h1C: return 16'h96FF;
      32'h1D: return 16'h993F;
      32'h1E: return 16'h5AC4;
      32'h1F: return 16'h9B7F;
      32'h20: return 16'h7A3F;
      32'h21: return 16'h0FF2;
      // multiply test: R3 <= R1 added R2 times, then ADD R3,#0 sets NZP from product
      32'h31: return 16'hD0A2;
      32'h32: return 16'h623F;
      32'h33: return 16'hD0B2;
      32'h34: return 16'h643F;
      32'h35: return 16'h56E0;
      32'h36: return 16'h14A0;
      32'h37: return 16'h0403;
      32'h38: return 16'h16C1;
      32'h39: return 16'h14BF;
      32'h3A: return 16'h03FD;
      32'h3B: return 16'h16E0;
      32'h3C: return 16'h763F;
      32'h3D: return 16'h0FF3;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic mem_t mem_image();
    mem_t m;
    m = '0;
    for (int unsigned i = 0; i < MEM_WORDS; i++) begin
      m[AW'(i)] = boot_word(i);
    end
    return m;
  endfunction

  localparam mem_t MEM_INIT = mem_image();

  // Active-low {g..a} hex digit decoder.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [2:0] nzp_of(input logic [15:0] v);
    if (v[15])          return 3'b100;
    else if (v == '0)   return 3'b010;
    else                return 3'b001;
  endfunction

  state_t            state;
  logic [15:0]       pc;
  logic [15:0]       ir;
  logic [15:0]       mar;
  logic [15:0]       mdr;
  logic [7:0][15:0]  rf;
  logic [2:0]        nzp;
  logic [15:0]       hex_reg;
  mem_t              mem;
  logic              run_q;
  logic              cont_q;

  logic              reset_ah;
  logic [3:0]        opcode;
  logic [2:0]        dr;
  logic [15:0]       sr1_val;
  logic [15:0]       sr2_val;
  logic [15:0]       alu_res;
  logic [15:0]       ea;
  logic [15:0]       mem_rdata;
  logic              mar_in_ram;

  assign reset_ah = ~Run & ~Continue;

  // Datapath: operand selection, ALU, effective address and memory/I-O read mux.
  always_comb begin
    opcode     = ir[15:12];
    dr         = ir[11:9];
    sr1_val    = rf[ir[8:6]];
    sr2_val    = ir[5] ? {{11{ir[4]}}, ir[4:0]} : rf[ir[2:0]];
    alu_res    = ~sr1_val;
    ea         = sr1_val + {{10{ir[5]}}, ir[5:0]};
    mar_in_ram = (mar < 16'(MEM_WORDS));
    mem_rdata  = 16'h0000;
    case (opcode)
      OP_ADD:  alu_res = sr1_val + sr2_val;
      OP_AND:  alu_res = sr1_val & sr2_val;
      default: alu_res = ~sr1_val;
    endcase
    if (mar == IO_ADDR) begin
      mem_rdata = {6'b0, SW};
    end else if (mar_in_ram) begin
      mem_rdata = mem[mar[AW-1:0]];
    end
  end

  // Control FSM, register file, memory and display registers.
  always_ff @(posedge Clk) begin
    run_q  <= Run;
    cont_q <= Continue;
    if (reset_ah) begin
      state   <= S_HALTED;
      pc      <= 16'h0000;
      ir      <= 16'h0000;
      mar     <= 16'h0000;
      mdr     <= 16'h0000;
      rf      <= '0;
      nzp     <= 3'b010;
      LED     <= 10'h000;
      hex_reg <= 16'h0000;
      mem     <= MEM_INIT;
      HEX0    <= seg7(4'h0);
      HEX1    <= seg7(4'h0);
      HEX2    <= seg7(4'h0);
      HEX3    <= seg7(4'h0);
      HEX4    <= seg7(4'h0);
      HEX5    <= seg7(4'h0);
    end else begin
      HEX0 <= seg7(hex_reg[3:0]);
      HEX1 <= seg7(hex_reg[7:4]);
      HEX2 <= seg7(hex_reg[11:8]);
      HEX3 <= seg7(hex_reg[15:12]);
      HEX4 <= seg7(pc[3:0]);
      HEX5 <= seg7(pc[7:4]);
      case (state)
        S_HALTED: begin
          if (!run_q && cont_q) state <= S_FETCH1;
        end
        S_FETCH1: begin
          mar   <= pc;
          pc    <= pc + 16'd1;
          state <= S_FETCH2;
        end
        S_FETCH2: begin
          mdr   <= mem_rdata;
          state <= S_FETCH3;
        end
        S_FETCH3: begin
          ir    <= mdr;
          state <= S_DECODE;
        end
        S_DECODE: begin
          case (opcode)
            OP_ADD, OP_AND, OP_NOT: state <= S_ALU;
            OP_BR:    state <= S_BR;
            OP_JMP:   state <= S_JMP;
            OP_JSR:   state <= S_JSR;
            OP_LDR:   state <= S_LDR1;
            OP_STR:   state <= S_STR1;
            OP_PAUSE: begin
              LED   <= ir[9:0];
              state <= S_PAUSE_HI;
            end
            default:  state <= S_FETCH1;
          endcase
        end
        S_ALU: begin
          rf[dr] <= alu_res;
          nzp    <= nzp_of(alu_res);
          state  <= S_FETCH1;
        end
        S_BR: begin
          if ((ir[11:9] & nzp) != 3'b000) pc <= pc + {{7{ir[8]}}, ir[8:0]};
          state <= S_FETCH1;
        end
        S_JMP: begin
          pc    <= sr1_val;
          state <= S_FETCH1;
        end
        S_JSR: begin
          rf[7] <= pc;
          pc    <= pc + {{5{ir[10]}}, ir[10:0]};
          state <= S_FETCH1;
        end
        S_LDR1: begin
          mar   <= ea;
          state <= S_LDR2;
        end
        S_LDR2: begin
          mdr   <= mem_rdata;
          state <= S_LDR3;
        end
        S_LDR3: begin
          rf[dr] <= mdr;
          nzp    <= nzp_of(mdr);
          state  <= S_FETCH1;
        end
        S_STR1: begin
          mar   <= ea;
          state <= S_STR2;
        end
        S_STR2: begin
          mdr   <= rf[dr];
          state <= S_STR3;
        end
        S_STR3: begin
          if (mar == IO_ADDR) begin
            hex_reg <= mdr;
          end else if (mar_in_ram) begin
            mem[mar[AW-1:0]] <= mdr;
          end
          state <= S_FETCH1;
        end
        // Hold until Continue is pressed, then until it is released.
        S_PAUSE_HI: begin
          if (!cont_q) state <= S_PAUSE_LO;
        end
        S_PAUSE_LO: begin
          if (cont_q) state <= S_FETCH1;
        end
        default: state <= S_HALTED;
      endcase
    end
  end

endmodule

// File: tb/tb_slc3_test_top.sv
// Directed bench for slc3_test_top: boots each preloaded test via the switches and
// checks hex display, LEDs, PC digits and key internal state against hand-computed values.
module tb_slc3_test_top;

  localparam logic [4:0] ST_HALTED   = 5'd0;
  localparam logic [4:0] ST_STR3     = 5'd14;
  localparam logic [4:0] ST_PAUSE_HI = 5'd15;

  localparam logic [6:0] SEG_TAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic       Clk = 1'b0;
  logic       Run;
  logic       Continue;
  logic [9:0] SW;
  logic [9:0] LED;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

  int n_checks = 0;
  int n_fail   = 0;

  slc3_test_top #(.MEM_WORDS(256)) dut (
    .Clk(Clk), .Run(Run), .Continue(Continue), .SW(SW), .LED(LED),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
  );

  always #5 Clk = ~Clk;

  function automatic logic [3:0] unseg(input logic [6:0] s);
    for (int i = 0; i < 16; i++) begin
      if (s == SEG_TAB[i]) return 4'(i);
    end
    return 4'hx;
  endfunction

  function automatic logic [15:0] disp_hex();
    return {unseg(HEX3), unseg(HEX2), unseg(HEX1), unseg(HEX0)};
  endfunction

  function automatic logic [15:0] disp_pc();
    return {8'h00, unseg(HEX5), unseg(HEX4)};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] want);
    n_checks++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic wait_state(input logic [4:0] st, input int bound, input string tag);
    logic [4:0] cur;
    int k;
    logic found;
    found = 1'b0;
    k = 0;
    while (!found && k < bound) begin
      tick(1);
      cur = dut.state;
      if (cur == st) found = 1'b1;
      k++;
    end
    chk(tag, 16'(found), 16'h0001);
  endtask

  task automatic pulse_cont();
    Continue = 1'b0;
    tick(2);
    Continue = 1'b1;
  endtask

  task automatic boot(input logic [9:0] sel, input string tag);
    Run = 1'b0; Continue = 1'b0; SW = sel;
    tick(2);
    Run = 1'b1; Continue = 1'b1;
    tick(2);
    Run = 1'b0;
    tick(2);
    Run = 1'b1;
    wait_state(ST_PAUSE_HI, 300, tag);
  endtask

  task automatic enter_operand(input logic [9:0] val, input int bound, input string tag);
    SW = val;
    pulse_cont();
    wait_state(ST_PAUSE_HI, bound, tag);
  endtask

  initial begin
    Run = 1'b0; Continue = 1'b0; SW = 10'h000;

    // reset state
    tick(2);
    chk("rst_pc_disp", disp_pc(), 16'h0000);
    chk("rst_hex_disp", disp_hex(), 16'h0000);
    chk("rst_state", 16'(dut.state), 16'(ST_HALTED));
    chk("rst_led", 16'(LED), 16'h0000);
    chk("rst_nzp", 16'(dut.nzp), 16'h0002);

    // I/O test at 0x003: first pause, then hex <= SW and pause again at 0x006
    boot(10'h003, "io3_first_pause");
    chk("io3_led1", 16'(LED), 16'h0003);
    Continue = 1'b0;
    tick(8);
    Continue = 1'b1;
    wait_state(ST_PAUSE_HI, 100, "io3_second_pause");
    chk("io3_hex", disp_hex(), 16'h0003);
    chk("io3_led2", 16'(LED), 16'h0006);
    chk("io3_pc_disp", disp_pc(), 16'h0007);

    // XOR test: A=0x30F, B=0x0F0
    boot(10'h014, "xor_pause_a");
    chk("xor_led_a", 16'(LED), 16'h00A1);
    enter_operand(10'h30F, 100, "xor_pause_b");
    chk("xor_led_b", 16'(LED), 16'h00B1);
    enter_operand(10'h0F0, 300, "xor_done");
    chk("xor_hex", disp_hex(), 16'h03FF);
    chk("xor_led_loop", 16'(LED), 16'h00A1);

    // multiply test: 0x3FF * 1
    boot(10'h031, "mul_pause_a");
    chk("mul_led_a", 16'(LED), 16'h00A2);
    enter_operand(10'h3FF, 100, "mul_pause_b");
    chk("mul_led_b", 16'(LED), 16'h00B2);
    enter_operand(10'h001, 300, "mul1_done");
    chk("mul1_hex", disp_hex(), 16'h03FF);
    chk("mul1_nzp", 16'(dut.nzp), 16'h0001);

    // 3 * 5 = 15, positive
    enter_operand(10'h003, 100, "mul2_pause_b");
    enter_operand(10'h005, 500, "mul2_done");
    chk("mul2_hex", disp_hex(), 16'h000F);
    chk("mul2_nzp", 16'(dut.nzp), 16'h0001);

    // 0 * 0 = 0, zero flag
    enter_operand(10'h000, 100, "mul3_pause_b");
    enter_operand(10'h000, 300, "mul3_done");
    chk("mul3_hex", disp_hex(), 16'h0000);
    chk("mul3_nzp", 16'(dut.nzp), 16'h0002);

    // 0x3FF * 0x3FF wraps to 0xF801, negative
    enter_operand(10'h3FF, 100, "mul4_pause_b");
    enter_operand(10'h3FF, 20000, "mul4_done");
    chk("mul4_hex", disp_hex(), 16'hF801);
    chk("mul4_nzp", 16'(dut.nzp), 16'h0004);

    // I/O test at 0x00B, then reset while the store is in flight
    boot(10'h00B, "io11_first_pause");
    chk("io11_led", 16'(LED), 16'h000B);
    enter_operand(10'h2A5, 100, "io11_second_pause");
    chk("io11_hex", disp_hex(), 16'h02A5);
    chk("io11_pc_disp", disp_pc(), 16'h000C);
    chk("io11_r1", dut.rf[1], 16'h02A5);
    SW = 10'h155;
    pulse_cont();
    wait_state(ST_STR3, 100, "abort_reach_store");
    Run = 1'b0; Continue = 1'b0;
    tick(1);
    chk("abort_pc", dut.pc, 16'h0000);
    chk("abort_state", 16'(dut.state), 16'(ST_HALTED));
    chk("abort_hex_reg", dut.hex_reg, 16'h0000);
    chk("abort_nzp", 16'(dut.nzp), 16'h0002);
    chk("abort_led", 16'(LED), 16'h0000);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("abort_r%0d", i), dut.rf[i], 16'h0000);
    end
    tick(1);
    chk("abort_hex_disp", disp_hex(), 16'h0000);
    chk("abort_pc_disp", disp_pc(), 16'h0000);

    // stays halted with both buttons released
    Run = 1'b1; Continue = 1'b1;
    tick(5);
    chk("idle_state", 16'(dut.state), 16'(ST_HALTED));
    chk("idle_pc", dut.pc, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
